// File: rtl/fir_xifu_wb_if.sv
// Purpose : bundles the EX/WB, memory-result, commit, X-interface result and regfile write signals of the WB stage.
// Latency : none (wiring only).
// Backpressure: ex2wb_ready_o / result_ready_i live here; the slave modport is the WB stage side.
interface fir_xifu_wb_if #(
    parameter int ID_WIDTH = 4,
    parameter int XRF_AW   = 5
);
    // EX/WB bundle
    logic                ex2wb_valid_i;
    logic                ex2wb_ready_o;
    logic [1:0]          ex2wb_instr_i;
    logic [31:0]         ex2wb_result_i;
    logic [4:0]          ex2wb_rs1_i;
    logic [XRF_AW-1:0]   ex2wb_rd_i;
    logic [ID_WIDTH-1:0] ex2wb_id_i;
    // memory result from the core
    logic                mem_result_valid_i;
    logic [ID_WIDTH-1:0] mem_result_id_i;
    logic [31:0]         mem_result_rdata_i;
    logic                mem_result_err_i;
    // commit channel
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    // X-interface result channel
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [31:0]         result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;
    logic                result_err_o;
    // XIFU register file write port
    logic                rf_we_o;
    logic [XRF_AW-1:0]   rf_waddr_o;
    logic [31:0]         rf_wdata_o;

    modport slave (
        input  ex2wb_valid_i, ex2wb_instr_i, ex2wb_result_i, ex2wb_rs1_i, ex2wb_rd_i, ex2wb_id_i,
        output ex2wb_ready_o,
        input  mem_result_valid_i, mem_result_id_i, mem_result_rdata_i, mem_result_err_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, result_err_o,
        input  result_ready_i,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output ex2wb_valid_i, ex2wb_instr_i, ex2wb_result_i, ex2wb_rs1_i, ex2wb_rd_i, ex2wb_id_i,
        input  ex2wb_ready_o,
        output mem_result_valid_i, mem_result_id_i, mem_result_rdata_i, mem_result_err_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, result_err_o,
        output result_ready_i,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/fir_xifu_wb.sv
// Purpose : FIR XIFU write-back stage; writes load/dotp data to the XIFU regfile and returns one X-interface result per live instruction.
// Latency : DOTP accept N -> rf_we/result_valid at N+1; LW/SW matching mem result M -> rf_we/result_valid at M+1.
// Backpressure: one instruction in flight; ex2wb_ready_o only in IDLE or when the pending result handshakes. Optional macro FIR_XIFU_WB_PERF_EN enables perf_cnt_o.
module fir_xifu_wb #(
    parameter int ID_WIDTH = 4,
    parameter int XRF_AW   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    fir_xifu_wb_if.slave bus,
    output logic [31:0] perf_cnt_o
);

    localparam logic [1:0] INSTR_NONE = 2'd0;
    localparam logic [1:0] INSTR_LW   = 2'd1;
    localparam logic [1:0] INSTR_SW   = 2'd2;
    localparam logic [1:0] INSTR_DOTP = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_RES = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          instr_q, instr_d;
    logic [31:0]         result_q, result_d;
    logic [4:0]          rs1_q, rs1_d;
    logic [XRF_AW-1:0]   rd_q, rd_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                err_q, err_d;
    logic                rf_we_q, rf_we_d;
    logic [XRF_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [31:0]         rf_wdata_q, rf_wdata_d;

    logic kill_held;
    logic kill_new;
    logic ready;
    logic accept;
    logic mem_hit;

    // Kill of the held instruction, kill of the incoming bundle, and the accept/match qualifiers.
    always_comb begin
        kill_held = bus.commit_valid_i && bus.commit_kill_i &&
                    (bus.commit_id_i == id_q) && (state_q != IDLE);
        kill_new  = bus.commit_valid_i && bus.commit_kill_i &&
                    (bus.commit_id_i == bus.ex2wb_id_i);
        ready     = (state_q == IDLE) || ((state_q == WAIT_RES) && bus.result_ready_i);
        accept    = bus.ex2wb_valid_i && ready && (bus.ex2wb_instr_i != INSTR_NONE) && !kill_new;
        mem_hit   = (state_q == WAIT_MEM) && bus.mem_result_valid_i &&
                    (bus.mem_result_id_i == id_q);
    end

    // State and held-bundle registers; clear_i behaves like reset but synchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            instr_q    <= INSTR_NONE;
            result_q   <= '0;
            rs1_q      <= '0;
            rd_q       <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            instr_q    <= INSTR_NONE;
            result_q   <= '0;
            rs1_q      <= '0;
            rd_q       <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            result_q   <= result_d;
            rs1_q      <= rs1_d;
            rd_q       <= rd_d;
            id_q       <= id_d;
            err_q      <= err_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Next state: kill beats a same-cycle memory result; an accept overrides the WAIT_RES exit.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        result_d   = result_q;
        rs1_d      = rs1_q;
        rd_d       = rd_q;
        id_d       = id_q;
        err_d      = err_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            WAIT_MEM: begin
                if (kill_held) begin
                    state_d = IDLE;
                end else if (mem_hit) begin
                    state_d = WAIT_RES;
                    err_d   = bus.mem_result_err_i;
                    if ((instr_q == INSTR_LW) && !bus.mem_result_err_i) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_q;
                        rf_wdata_d = bus.mem_result_rdata_i;
                    end
                end
            end
            WAIT_RES: begin
                if (kill_held || bus.result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            instr_d  = bus.ex2wb_instr_i;
            result_d = bus.ex2wb_result_i;
            rs1_d    = bus.ex2wb_rs1_i;
            rd_d     = bus.ex2wb_rd_i;
            id_d     = bus.ex2wb_id_i;
            err_d    = 1'b0;
            if (bus.ex2wb_instr_i == INSTR_DOTP) begin
                state_d    = WAIT_RES;
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.ex2wb_rd_i;
                rf_wdata_d = bus.ex2wb_result_i;
            end else begin
                state_d = WAIT_MEM;
            end
        end
    end

    // Outputs: result channel driven only in WAIT_RES and suppressed while the held id is being killed.
    always_comb begin
        bus.ex2wb_ready_o  = ready;
        bus.result_valid_o = 1'b0;
        bus.result_id_o    = '0;
        bus.result_data_o  = '0;
        bus.result_rd_o    = '0;
        bus.result_we_o    = 1'b0;
        bus.result_err_o   = 1'b0;
        bus.rf_we_o        = rf_we_q;
        bus.rf_waddr_o     = rf_waddr_q;
        bus.rf_wdata_o     = rf_wdata_q;
        if ((state_q == WAIT_RES) && !kill_held) begin
            bus.result_valid_o = 1'b1;
            bus.result_id_o    = id_q;
            if (instr_q != INSTR_DOTP) begin
                bus.result_rd_o   = rs1_q;
                bus.result_data_o = result_q;
                bus.result_we_o   = !err_q;
                bus.result_err_o  = err_q;
            end
        end
    end

`ifdef FIR_XIFU_WB_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Retired-instruction counter, bumped on each completed result handshake.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (bus.result_valid_o && bus.result_ready_i) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    // Counter register, cleared by reset and soft clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cnt_q <= '0;
        end else if (clear_i) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_cnt_o = perf_cnt_q;
`else
    assign perf_cnt_o = 32'd0;
`endif

endmodule
